alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// Four-state instruction sequencer (IDLE/READ/EXEC/WB) around an 8x32 register file and an external ALU.
// Optional feature macro ALU_SEQ_ZERO_REG_EN: register 0 reads as zero and ignores all writes.
module alu_sequencer #(
  parameter int unsigned PC_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instr,
  input  logic            rf_wr_en,
  input  logic [2:0]      rf_wr_addr,
  input  logic [31:0]     rf_wr_data,
  output logic [31:0]     alu_ip_0,
  output logic [31:0]     alu_ip_1,
  output logic [2:0]      alu_opcode,
  input  logic [31:0]     alu_op_0,
  input  logic            alu_change_pc,
  output logic [PC_W-1:0] pc,
  output logic            wb_valid,
  output logic [2:0]      wb_addr,
  output logic [31:0]     wb_data
);

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 3;
  localparam int unsigned REGS = 8;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_e;

  state_e          state_q, state_d;
  logic            ready_q, ready_d;
  logic [AW-1:0]   opcode_q, opcode_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [AW-1:0]   rs1_q, rs1_d;
  logic [AW-1:0]   rs2_q, rs2_d;
  logic [PC_W-1:0] target_q, target_d;
  logic [DW-1:0]   alu_ip_0_q, alu_ip_0_d;
  logic [DW-1:0]   alu_ip_1_q, alu_ip_1_d;
  logic [AW-1:0]   alu_opcode_q, alu_opcode_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            wb_valid_q, wb_valid_d;
  logic [AW-1:0]   wb_addr_q, wb_addr_d;
  logic [DW-1:0]   wb_data_q, wb_data_d;
  logic [DW-1:0]   rf_q [REGS];
  logic [DW-1:0]   rf_d [REGS];

  // Next-state, operand capture and register-file update; writeback is applied after the host write so it wins.
  always_comb begin
    state_d      = state_q;
    ready_d      = ready_q;
    opcode_d     = opcode_q;
    rd_d         = rd_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    target_d     = target_q;
    alu_ip_0_d   = alu_ip_0_q;
    alu_ip_1_d   = alu_ip_1_q;
    alu_opcode_d = alu_opcode_q;
    pc_d         = pc_q;
    wb_valid_d   = 1'b0;
    wb_addr_d    = wb_addr_q;
    wb_data_d    = wb_data_q;
    rf_d         = rf_q;

    if (rf_wr_en) rf_d[rf_wr_addr] = rf_wr_data;

    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          opcode_d = instr[31:29];
          rd_d     = instr[28:26];
          rs1_d    = instr[25:23];
          rs2_d    = instr[22:20];
          target_d = PC_W'(instr[19:0]);
          ready_d  = 1'b0;
          state_d  = READ;
        end
      end
      READ: begin
        alu_ip_0_d   = rf_q[rs1_q];
        alu_ip_1_d   = rf_q[rs2_q];
        alu_opcode_d = opcode_q;
        state_d      = EXEC;
      end
      EXEC: begin
        if (alu_change_pc) begin
          pc_d = target_q;
        end else begin
          wb_valid_d  = 1'b1;
          wb_addr_d   = rd_q;
          wb_data_d   = alu_op_0;
          rf_d[rd_q]  = alu_op_0;
          pc_d        = pc_q + PC_W'(1);
        end
        state_d = WB;
      end
      default: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
    endcase

`ifdef ALU_SEQ_ZERO_REG_EN
    rf_d[0] = '0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ready_q      <= 1'b1;
      opcode_q     <= '0;
      rd_q         <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      target_q     <= '0;
      alu_ip_0_q   <= '0;
      alu_ip_1_q   <= '0;
      alu_opcode_q <= '0;
      pc_q         <= '0;
      wb_valid_q   <= 1'b0;
      wb_addr_q    <= '0;
      wb_data_q    <= '0;
      for (int i = 0; i < int'(REGS); i++) rf_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      opcode_q     <= opcode_d;
      rd_q         <= rd_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      target_q     <= target_d;
      alu_ip_0_q   <= alu_ip_0_d;
      alu_ip_1_q   <= alu_ip_1_d;
      alu_opcode_q <= alu_opcode_d;
      pc_q         <= pc_d;
      wb_valid_q   <= wb_valid_d;
      wb_addr_q    <= wb_addr_d;
      wb_data_q    <= wb_data_d;
      for (int i = 0; i < int'(REGS); i++) rf_q[i] <= rf_d[i];
    end
  end

  assign instr_ready = ready_q;
  assign alu_ip_0    = alu_ip_0_q;
  assign alu_ip_1    = alu_ip_1_q;
  assign alu_opcode  = alu_opcode_q;
  assign pc          = pc_q;
  assign wb_valid    = wb_valid_q;
  assign wb_addr     = wb_addr_q;
  assign wb_data     = wb_data_q;

endmodule
